hdr_weight_merge: RTL
=====================

# hdr_weight_merge

Consumer of the per-exposure triangular weights: takes three co-located exposure pixels (high, mid, low) and their weights, and produces the normalized weighted average `sum(w_i*p_i) / sum(w_i)` as an unsigned fixed-point merged pixel. It sits directly after the weight generator in the HDR pipeline. It uses a valid/ready handshake on both sides and a bit-serial restoring divider, so it runs one pixel per division window.

## Interface
- `PIX_W`, default 5: pixel width per exposure.
- `W_W`, default 12: weight width.
- `FRAC`, default 3: fractional bits in the result. `Q_W = PIX_W + FRAC`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low. Clock is `clk`.
- `in_valid`  in  1  input pixel and weights are valid.
- `in_ready`  out  1  block can accept an input.
- `pixel_high`, `pixel_mid`, `pixel_low`  in  PIX_W each  exposure pixels.
- `w_high`, `w_mid`, `w_low`  in  W_W each  matching weights.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_pixel`  out  Q_W  merged pixel, unsigned, `FRAC` fractional bits.
- `div_zero`  out  1  set with the result when the weight sum is 0.

## Operation
- States: IDLE, MAC, DIV, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`, register the 3 pixels and 3 weights, then go to MAC.
- **MAC** (1 cycle)
  - `num = sum(w_i*p_i)`, `NUM_W = W_W+PIX_W+2` bits.
  - `den = sum(w_i)`, `DEN_W = W_W+2` bits.
  - Both are registered, and the divider is loaded with dividend `num << FRAC` (extra LSB if HDR_ROUND_EN).
  - If `den==0`, go straight to DONE with `out_pixel=0` and `div_zero=1`. Otherwise go to DIV.
- **DIV**
  - Restoring division, one quotient bit per cycle, MSB first.
  - Remainder is DEN_W+1 bits.
  - Iteration count `ITER = Q_W` (`Q_W+1` with rounding).
  - The iteration counter counts down to 0, then go to DONE.
- **Quotient width**: results whose integer part exceeds `PIX_W` bits saturate `out_pixel` to all-ones. This cannot occur for in-range inputs, since the average never exceeds the max pixel; only rounding can overflow.
- **DONE**
  - `out_valid=1`, with `out_pixel` and `div_zero` held stable.
  - On `out_ready`, go to IDLE.
- `in_ready=0` in MAC, DIV and DONE. Inputs are ignored there.
- No input field is sampled outside the IDLE accept cycle.

## Timing
- **Reset values**: state IDLE, `in_ready=1` (combinational from state), `out_valid=0`, `out_pixel=0`, `div_zero=0`, all internal registers 0.
- **Latency**: input accepted at edge k, then MAC during k..k+1, then DIV for ITER cycles. `out_valid` rises at edge k+1+ITER+... precisely, it is first high in the cycle after the last DIV cycle, which is `ITER+2` cycles after acceptance.
- **Throughput** with `out_ready` held high: one result every `ITER+3` cycles, i.e. 11 with defaults (12 rounded).
- **Backpressure**: `out_pixel` and `div_zero` stay constant while `out_valid && !out_ready`, for any duration.
- **Simultaneous events**: `out_ready` during DONE and `in_valid` in the same cycle are not merged. The input is accepted only on the next cycle, in IDLE.
- **Reset mid-operation** (any state): the next cycle is IDLE with reset values and the partial result is discarded.
- `out_ready` asserted while `out_valid=0` has no effect.

## Configuration
- `HDR_ROUND_EN`
  - Defined: one extra quotient bit is computed (`ITER=Q_W+1`) and the result is round-half-up (`q[Q_W:1] + q[0]`), saturating at `2^Q_W-1`.
  - Undefined: truncation (`ITER=Q_W`), no adder.

## Structure
- Shared package `hdr_pkg`:
  - state enum (IDLE/MAC/DIV/DONE);
  - default `PIX_W`, `W_W`, `FRAC` constants;
  - derived width functions for `NUM_W`, `DEN_W`, `Q_W`.
- Sub-module `hdr_serial_div`: start/busy/done restoring divider parameterized by dividend, divisor and quotient widths. The top level owns the FSM, the MAC and the handshake.

## Test plan
- Reset, then idle → `in_ready=1`, `out_valid=0`, `out_pixel=0`.
- All pixels 10, all weights 11 → num 330, den 33, `out_pixel=80` (10.0), `div_zero=0`, `out_valid` 10 cycles after accept.
- `p=(31,16,0)`, `w=(1,16,1)` → num 287, den 18; result 127 without `HDR_ROUND_EN`, 128 with it.
- All weights 0 → `out_pixel=0`, `div_zero=1`; `out_valid` follows MAC with no DIV cycles.
- `out_ready` low for 5 cycles in DONE → `out_pixel` stable, `in_ready=0`, `in_valid` pulses ignored; accepted result appears after release.
- `rst_n` low for 1 cycle mid-DIV → IDLE next cycle, `out_valid` never asserts for that pixel; a following input produces the correct result.

Source files
------------

// File: rtl/hdr_pkg.sv
// hdr_pkg: shared definitions for the HDR weighted-merge slice.
//   - hdr_state_e : controller states of hdr_weight_merge
//   - HDR_PIX_W / HDR_W_W / HDR_FRAC : default pixel, weight and fraction widths
//   - hdr_num_w / hdr_den_w / hdr_q_w : derived datapath widths
package hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } hdr_state_e;

    localparam int HDR_PIX_W = 5;
    localparam int HDR_W_W   = 12;
    localparam int HDR_FRAC  = 3;

    // Sum of three w*p products needs two carry bits above a single product.
    function automatic int hdr_num_w(input int w_w, input int pix_w);
        return w_w + pix_w + 2;
    endfunction

    // Sum of three weights needs two carry bits.
    function automatic int hdr_den_w(input int w_w);
        return w_w + 2;
    endfunction

    function automatic int hdr_q_w(input int pix_w, input int frac);
        return pix_w + frac;
    endfunction

endpackage

// File: rtl/hdr_serial_div.sv
// hdr_serial_div: bit-serial restoring divider, one quotient bit per cycle, MSB first.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : load dividend/divisor and begin (ignored while busy)
//   dividend    : DVD_W-bit dividend; its upper DVD_W-QW bits are taken at start,
//                 its low QW bits are read one per cycle and must stay stable while busy
//   divisor     : DVS_W-bit divisor, must stay stable from start until done
//   busy        : iterations in progress
//   done        : high during the final iteration cycle; quotient is valid afterwards
//   quotient    : QW-bit quotient, held until the next start
//   overflow    : true quotient does not fit in QW bits (upper dividend part >= divisor)
module hdr_serial_div
    import hdr_pkg::*;
#(
    parameter int DVD_W = 22,
    parameter int DVS_W = 14,
    parameter int QW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient,
    output logic             overflow
);

    localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic [QW-1:0]    dvd_lo;
    logic [DVS_W:0]   hi_ext;
    logic [DVS_W:0]   trial;
    logic             fits;

    always_comb begin
        dvd_lo = dividend[QW-1:0];
        hi_ext = (DVS_W + 1)'(dividend[DVD_W-1:QW]);
        // Partial remainder shifted left with the next dividend bit brought down.
        trial  = {rem_q, dvd_lo[cnt_q]};
        fits   = (trial >= {1'b0, divisor});

        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        ovf_d  = ovf_q;

        if (start && !busy_q) begin
            // If the upper part already reaches the divisor, the quotient needs
            // more than QW bits; flag it and let the iterations run harmlessly.
            rem_d  = hi_ext[DVS_W-1:0];
            ovf_d  = (hi_ext >= {1'b0, divisor});
            quo_d  = '0;
            cnt_d  = CNT_W'(QW - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = fits ? DVS_W'(trial - {1'b0, divisor}) : trial[DVS_W-1:0];
            quo_d = {quo_q[QW-2:0], fits};
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == '0);
    assign quotient = quo_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/hdr_weight_merge.sv
// hdr_weight_merge: normalized weighted average of three exposures,
//   out_pixel = sum(w_i*p_i) / sum(w_i), unsigned with FRAC fractional bits.
//
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   in_valid / in_ready              : input handshake (ready only in IDLE)
//   pixel_high/mid/low [PIX_W]       : exposure pixels
//   w_high/mid/low [W_W]             : matching weights
//   out_valid / out_ready            : output handshake (valid only in DONE)
//   out_pixel [Q_W]                  : merged pixel, saturates to all-ones
//   div_zero                         : weight sum was zero, out_pixel forced to 0
//
// Build option: HDR_ROUND_EN computes one extra quotient bit and rounds half-up;
// without it the result is truncated.
module hdr_weight_merge
    import hdr_pkg::*;
#(
    parameter  int PIX_W = HDR_PIX_W,
    parameter  int W_W   = HDR_W_W,
    parameter  int FRAC  = HDR_FRAC,
    localparam int Q_W   = hdr_q_w(PIX_W, FRAC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pixel_high,
    input  logic [PIX_W-1:0] pixel_mid,
    input  logic [PIX_W-1:0] pixel_low,
    input  logic [W_W-1:0]   w_high,
    input  logic [W_W-1:0]   w_mid,
    input  logic [W_W-1:0]   w_low,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   out_pixel,
    output logic             div_zero
);

    localparam int NUM_W = hdr_num_w(W_W, PIX_W);
    localparam int DEN_W = hdr_den_w(W_W);
`ifdef HDR_ROUND_EN
    localparam int RND   = 1;
`else
    localparam int RND   = 0;
`endif
    localparam int ITER  = Q_W + RND;
    localparam int DVD_W = NUM_W + FRAC + RND;

    hdr_state_e       state_q, state_d;
    logic [PIX_W-1:0] p_high_q, p_high_d, p_mid_q, p_mid_d, p_low_q, p_low_d;
    logic [W_W-1:0]   w_high_q, w_high_d, w_mid_q, w_mid_d, w_low_q, w_low_d;
    logic [NUM_W-1:0] num_q, num_d, num_mac;
    logic [DEN_W-1:0] den_q, den_d, den_mac;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] div_num_src;
    logic [DVD_W-1:0] div_dividend;
    logic [DEN_W-1:0] div_divisor;
    logic [ITER-1:0]  div_quot;
    logic             div_ovf;
    logic [Q_W-1:0]   result;

    always_comb begin
        num_mac = NUM_W'(w_high_q) * NUM_W'(p_high_q)
                + NUM_W'(w_mid_q)  * NUM_W'(p_mid_q)
                + NUM_W'(w_low_q)  * NUM_W'(p_low_q);
        den_mac = DEN_W'(w_high_q) + DEN_W'(w_mid_q) + DEN_W'(w_low_q);
    end

    always_comb begin
        state_d   = state_q;
        p_high_d  = p_high_q;
        p_mid_d   = p_mid_q;
        p_low_d   = p_low_q;
        w_high_d  = w_high_q;
        w_mid_d   = w_mid_q;
        w_low_d   = w_low_q;
        num_d     = num_q;
        den_d     = den_q;
        div_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    p_high_d = pixel_high;
                    p_mid_d  = pixel_mid;
                    p_low_d  = pixel_low;
                    w_high_d = w_high;
                    w_mid_d  = w_mid;
                    w_low_d  = w_low;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                num_d = num_mac;
                den_d = den_mac;
                if (den_mac == '0) begin
                    state_d = ST_DONE;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            p_high_q <= '0;
            p_mid_q  <= '0;
            p_low_q  <= '0;
            w_high_q <= '0;
            w_mid_q  <= '0;
            w_low_q  <= '0;
            num_q    <= '0;
            den_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_high_q <= p_high_d;
            p_mid_q  <= p_mid_d;
            p_low_q  <= p_low_d;
            w_high_q <= w_high_d;
            w_mid_q  <= w_mid_d;
            w_low_q  <= w_low_d;
            num_q    <= num_d;
            den_q    <= den_d;
        end
    end

    // The divider loads straight from the MAC result in the MAC cycle, then
    // reads the registered copies (same values) while it iterates.
    assign div_num_src  = div_busy ? num_q : num_mac;
    assign div_dividend = DVD_W'(div_num_src) << (FRAC + RND);
    assign div_divisor  = div_busy ? den_q : den_mac;

    hdr_serial_div #(
        .DVD_W (DVD_W),
        .DVS_W (DEN_W),
        .QW    (ITER)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot),
        .overflow (div_ovf)
    );

`ifdef HDR_ROUND_EN
    // Drop the guard bit and add it back as the rounding increment.
    logic [Q_W:0] rnd_sum;
    assign rnd_sum = {1'b0, div_quot[Q_W:1]} + {{Q_W{1'b0}}, div_quot[0]};
    assign result  = (div_ovf || rnd_sum[Q_W]) ? '1 : rnd_sum[Q_W-1:0];
`else
    assign result  = div_ovf ? '1 : div_quot;
`endif

    // Divider state is frozen once idle, so these are stable throughout DONE.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign div_zero  = (state_q == ST_DONE) && (den_q == '0);
    assign out_pixel = ((state_q == ST_DONE) && (den_q != '0)) ? result : '0;

endmodule
